// File: rtl/display_console_writer.sv
// Display-port console writer: renders DDR characters into a circular COLS x ROWS text VRAM,
// handling cursor motion, control codes and hardware scroll, and answers with DisplayReady.
module display_console_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Char_Valid,
  input  logic [15:0]       Char_In,
  output logic              DisplayReady,
  output logic              Busy,
  output logic              Overrun,
  output logic              VRAM_WE,
  output logic [ADDR_W-1:0] VRAM_Addr,
  output logic [7:0]        VRAM_Data,
  output logic [4:0]        Cursor_Row,
  output logic [6:0]        Cursor_Col,
  output logic [4:0]        Top_Row
);
  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, ERASE, SCROLL, DONE} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS*ROWS-1);
  localparam logic [4:0]        ROW_LAST = 5'(ROWS-1);
  localparam logic [6:0]        COL_LAST = 7'(COLS-1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          c_q, c_d;
  logic [4:0]          row_q, row_d, top_q, top_d;
  logic [6:0]          col_q, col_d;
  logic                we_q, we_d, rdy_q, rdy_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                accept, do_nl;
  logic [7:0]          ch;
  logic                unused_hi;

  assign ch        = Char_In[7:0];
  assign unused_hi = ^Char_In[15:8];
  // Busy is the visible (registered) state, so a char is only taken once IDLE is on the outputs.
  assign accept    = Char_Valid && (state_q == IDLE) && !busy_q;

  function automatic logic [ADDR_W-1:0] phys(input logic [4:0] t, input logic [4:0] r,
                                             input logic [6:0] c);
    logic [5:0] s;
    s = {1'b0, t} + {1'b0, r};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return ADDR_W'(s) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; c_d = c_q;
    row_d = row_q; col_d = col_q; top_d = top_q;
    we_d = 1'b0; addr_d = addr_q; data_d = data_q;
    rdy_d = 1'b0; busy_d = 1'b1; ovr_d = ovr_q | (Char_Valid & ~accept);
    do_nl = 1'b0;
    case (state_q)
      CLEAR: begin
        we_d = 1'b1; addr_d = cnt_q; data_d = 8'h20;
        if (cnt_q == CLR_LAST) begin cnt_d = '0; state_d = DONE; end
        else cnt_d = cnt_q + 1'b1;
      end
      IDLE: begin
        busy_d = accept;
        if (accept) begin
          c_d = ch;
          if (ch >= 8'h20 && ch <= 8'h7E) state_d = WRITE;
          else begin
            case (ch)
              8'h0A: begin col_d = '0; do_nl = 1'b1; end
              8'h0D: begin col_d = '0; state_d = DONE; end
              8'h08: begin
                if (col_q != '0) begin col_d = col_q - 7'd1; state_d = ERASE; end
                else if (row_q != '0) begin
                  row_d = row_q - 5'd1; col_d = COL_LAST; state_d = ERASE;
                end else state_d = DONE;
              end
              8'h0C: begin
                row_d = '0; col_d = '0; top_d = '0; cnt_d = '0; state_d = CLEAR;
              end
              default: state_d = DONE;
            endcase
          end
        end
      end
      WRITE: begin
        we_d = 1'b1; addr_d = phys(top_q, row_q, col_q); data_d = c_q;
        if (col_q == COL_LAST) begin col_d = '0; do_nl = 1'b1; end
        else begin col_d = col_q + 7'd1; state_d = DONE; end
      end
      ERASE: begin
        we_d = 1'b1; addr_d = phys(top_q, row_q, col_q); data_d = 8'h20; state_d = DONE;
      end
      SCROLL: begin
        // top_q already points past the old top row, so ROW_LAST is the freshly exposed row.
        we_d = 1'b1; addr_d = phys(top_q, ROW_LAST, cnt_q[6:0]); data_d = 8'h20;
        if (cnt_q[6:0] == COL_LAST) begin cnt_d = '0; state_d = DONE; end
        else cnt_d = cnt_q + 1'b1;
      end
      DONE: begin rdy_d = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    if (do_nl) begin
      if (row_q != ROW_LAST) begin row_d = row_q + 5'd1; state_d = DONE; end
      else begin
        top_d = (top_q == ROW_LAST) ? 5'd0 : top_q + 5'd1;
        cnt_d = '0; state_d = SCROLL;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= CLEAR; cnt_q <= '0; c_q <= '0;
      row_q <= '0; col_q <= '0; top_q <= '0;
      we_q <= 1'b0; addr_q <= '0; data_q <= '0;
      rdy_q <= 1'b0; busy_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; c_q <= c_d;
      row_q <= row_d; col_q <= col_d; top_q <= top_d;
      we_q <= we_d; addr_q <= addr_d; data_q <= data_d;
      rdy_q <= rdy_d; busy_q <= busy_d; ovr_q <= ovr_d;
    end
  end

  assign DisplayReady = rdy_q;
  assign Busy         = busy_q;
  assign Overrun      = ovr_q;
  assign VRAM_WE      = we_q;
  assign VRAM_Addr    = addr_q;
  assign VRAM_Data    = data_q;
  assign Cursor_Row   = row_q;
  assign Cursor_Col   = col_q;
  assign Top_Row      = top_q;
endmodule

// File: tb/tb_display_console_writer.sv
// Randomized scoreboard bench for display_console_writer against a screen-level reference model.
module tb_display_console_writer;
  localparam int COLS = 80, ROWS = 30, AW = 12;

  logic          Clk = 1'b0, Reset = 1'b1, Char_Valid = 1'b0;
  logic [15:0]   Char_In = '0;
  logic          DisplayReady, Busy, Overrun, VRAM_WE;
  logic [AW-1:0] VRAM_Addr;
  logic [7:0]    VRAM_Data;
  logic [4:0]    Cursor_Row, Top_Row;
  logic [6:0]    Cursor_Col;

  display_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Char_Valid(Char_Valid), .Char_In(Char_In),
    .DisplayReady(DisplayReady), .Busy(Busy), .Overrun(Overrun), .VRAM_WE(VRAM_WE),
    .VRAM_Addr(VRAM_Addr), .VRAM_Data(VRAM_Data), .Cursor_Row(Cursor_Row),
    .Cursor_Col(Cursor_Col), .Top_Row(Top_Row));

  always #5 Clk = ~Clk;

  typedef struct {bit rdy; int a; int d; int r; int c; int t;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  vecs = 0, errs = 0;
  int  mrow = 0, mcol = 0, mtop = 0;

  task automatic chk(input string nm, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: logical screen rows map onto VRAM rows rotated by the top offset.
  function automatic int phys(input int r, input int c);
    return ((mtop + r) % ROWS) * COLS + c;
  endfunction

  task automatic push_w(input int a, input int d);
    ev_t e;
    e = '{0, a, d, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  task automatic push_rdy();
    ev_t e;
    e = '{1, 0, 0, mrow, mcol, mtop};
    exp_q.push_back(e);
  endtask

  task automatic newline();
    if (mrow < ROWS - 1) mrow++;
    else begin
      mtop = (mtop + 1) % ROWS;
      for (int c = 0; c < COLS; c++) push_w(phys(ROWS - 1, c), 32);
    end
  endtask

  task automatic model_clear();
    mrow = 0; mcol = 0; mtop = 0;
    for (int i = 0; i < COLS * ROWS; i++) push_w(i, 32);
    push_rdy();
  endtask

  task automatic model_char(input int ch);
    if (ch == 12) model_clear();
    else begin
      if (ch >= 32 && ch <= 126) begin
        push_w(phys(mrow, mcol), ch);
        mcol++;
        if (mcol == COLS) begin mcol = 0; newline(); end
      end else if (ch == 10) begin
        mcol = 0; newline();
      end else if (ch == 13) mcol = 0;
      else if (ch == 8 && (mcol > 0 || mrow > 0)) begin
        if (mcol > 0) mcol--;
        else begin mrow--; mcol = COLS - 1; end
        push_w(phys(mrow, mcol), 32);
      end
      push_rdy();
    end
  endtask

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 20000) begin @(negedge Clk); n++; end
    if (n >= 20000) begin
      errs++;
      $display("FAIL wait_idle: timeout with %0d events still expected", exp_q.size());
      finish_now();
    end
  endtask

  task automatic send(input int ch);
    wait_idle();
    model_char(ch);
    Char_In = {8'($urandom), 8'(ch)};
    Char_Valid = 1'b1;
    @(negedge Clk);
    Char_Valid = 1'b0;
  endtask

  task automatic reset_outputs_chk(input string nm);
    chk(nm, int'({VRAM_WE, DisplayReady, Busy, Overrun, Top_Row, Cursor_Row, Cursor_Col}), 0);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2 Reset = 1'b1;
    exp_q.delete();
    model_clear();
    #1 reset_outputs_chk("reset_mid_op_outputs");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    wait_idle();
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (VRAM_WE) begin
        if (exp_q.size() == 0 || exp_q[0].rdy) chk("spurious_write_addr", int'(VRAM_Addr), -1);
        else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", int'(VRAM_Addr), mon_e.a);
          chk("write_data", int'(VRAM_Data), mon_e.d);
        end
      end
      if (DisplayReady) begin
        if (exp_q.size() == 0 || !exp_q[0].rdy) chk("spurious_ready", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ready_row", int'(Cursor_Row), mon_e.r);
          chk("ready_col", int'(Cursor_Col), mon_e.c);
          chk("ready_top", int'(Top_Row), mon_e.t);
        end
      end
    end
  end

  initial begin
    int r, ch;
    model_clear();
    repeat (2) @(negedge Clk);
    reset_outputs_chk("reset_outputs");
    Reset = 1'b0;
    wait_idle();
    chk("busy_after_clear", int'(Busy), 0);

    // Printable latency: accept edge T, write visible after T+1, ready after T+2.
    model_char(8'h41);
    Char_In = 16'hA541; Char_Valid = 1'b1;
    @(negedge Clk); Char_Valid = 1'b0;
    chk("we_after_T", int'(VRAM_WE), 0);
    @(negedge Clk);
    chk("we_after_T1", int'(VRAM_WE), 1);
    @(negedge Clk);
    chk("ready_after_T2", int'(DisplayReady), 1);
    wait_idle();
    chk("col_after_A", int'(Cursor_Col), 1);

    for (int i = 0; i < 80; i++) send($urandom_range(8'h20, 8'h7E));
    wait_idle();
    chk("cursor_after_81", int'({Cursor_Row, Cursor_Col}), int'({5'd1, 7'd1}));

    for (int i = 0; i < 28; i++) send(10);
    for (int i = 0; i < 5; i++) send(8'h78);
    send(10);
    repeat (5) @(negedge Clk);
    Char_In = 16'h0042; Char_Valid = 1'b1;
    @(negedge Clk); Char_Valid = 1'b0;
    chk("overrun_during_scroll", int'(Overrun), 1);
    wait_idle();
    chk("cursor_after_scroll", int'({Top_Row, Cursor_Row, Cursor_Col}),
        int'({5'd1, 5'd29, 7'd0}));

    send(10);
    repeat (20) @(negedge Clk);
    chk("overrun_sticky", int'(Overrun), 1);
    do_reset();

    send(8);
    for (int i = 0; i < 3; i++) send(10);
    send(8);
    wait_idle();
    chk("cursor_after_bs", int'({Cursor_Row, Cursor_Col}), int'({5'd2, 7'd79}));

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      ch = $urandom_range(8'h20, 8'h7E);
      else if (r < 72) ch = 10;
      else if (r < 80) ch = 13;
      else if (r < 90) ch = 8;
      else if (r < 92) ch = 12;
      else if (r < 96) ch = $urandom_range(0, 7);
      else             ch = $urandom_range(8'h7F, 8'hFF);
      send(ch);
    end
    wait_idle();
    chk("overrun_still_clear", int'(Overrun), 0);
    finish_now();
  end
endmodule
